// File: rtl/memory_subsystem_pkg.sv
// memory_subsystem_pkg: shared access encodings, console default address, port FSM states and byte-lane merge helper.
package memory_subsystem_pkg;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic ENABLE = 1'b1;
  localparam logic [31:0] CONSOLE_DEFAULT_ADDRESS = 32'h1000_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_e;
  // mask[3] owns bits 7:0 and mask[0] owns bits 31:24 (lane order reversed w.r.t. bit order)
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] wdata,
                                              input logic [3:0] mask);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) if (mask[3-b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/memory_subsystem_console_fifo.sv
// console_fifo: byte FIFO draining head-first on valid & ready; accepts a push while full if a pop happens the same edge.
// Ports: clk, reset (async, active-high); push_i/data_i enqueue; valid_o/data_o/ready_i drain; full_o/empty_o flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] data_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  input  logic       ready_i,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:0] slot_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q;
  logic pop, do_push;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (PW+1)'(DEPTH);
  assign valid_o = !empty_o;
  assign data_o = valid_o ? slot_q[head_q] : 8'h0;
  assign pop = valid_o && ready_i;
  assign do_push = push_i && (!full_o || pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_q + PW'(pop);
      tail_q <= tail_q + PW'(do_push);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (do_push) slot_q[tail_q] <= data_i;
endmodule

// File: rtl/memory_subsystem.sv
// memory_subsystem: word-addressed backing store with independent instruction and data ports and optional console MMIO FIFO.
// Ports: clk, reset (async, active-high); instruction_memory_interface_* read-only port;
// data_memory_interface_* read/write port with byte mask and error; console_valid/console_data/console_ready byte stream.
// Each port: IDLE accepts, WAIT burns LATENCY cycles (aborts if enable drops), RESP pulses ready for one cycle.
// Define MEMORY_SUBSYSTEM_CONSOLE_EN to map CONSOLE_ADDRESS onto the console FIFO; otherwise it is plain (out-of-range) memory.
module memory_subsystem
  import memory_subsystem_pkg::*;
#(
  parameter int          DEPTH_WORDS     = 8192,
  parameter int          LATENCY         = 0,
  parameter logic [31:0] CONSOLE_ADDRESS = CONSOLE_DEFAULT_ADDRESS,
  parameter int          CONSOLE_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_memory_interface_enable,
  input  logic [31:0] instruction_memory_interface_address,
  output logic [31:0] instruction_memory_interface_data,
  output logic        instruction_memory_interface_ready,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  input  logic [31:0] data_memory_interface_write_data,
  output logic [31:0] data_memory_interface_read_data,
  output logic        data_memory_interface_ready,
  output logic        data_memory_interface_error,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  // WAIT exits on the edge where the counter is already zero, so load LATENCY-1
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
  localparam port_state_e ACCEPT_NEXT = LATENCY > 0 ? WAIT : RESP;
  logic [31:0] mem [DEPTH_WORDS];
  port_state_e i_state_q, d_state_q;
  logic [3:0] i_cnt_q, d_cnt_q;
  logic [29:0] i_word_q, d_word_q;
  logic [31:0] i_data_q, d_rdata_q, d_wdata_q;
  logic i_ready_q, d_ready_q, d_error_q, d_write_q;
  logic [3:0] d_mask_q;
  logic i_in_range, d_in_range, d_console, d_commit, con_full, con_empty, con_stall;
  logic unused_inputs;
  assign unused_inputs = ^{instruction_memory_interface_address[1:0], data_memory_interface_address[1:0], console_ready};
  assign i_in_range = 32'(i_word_q) < 32'(DEPTH_WORDS);
  assign d_in_range = 32'(d_word_q) < 32'(DEPTH_WORDS);
`ifdef MEMORY_SUBSYSTEM_CONSOLE_EN
  logic con_push, con_pop;
  assign d_console = d_word_q == CONSOLE_ADDRESS[31:2];
  assign con_pop = console_valid && console_ready;
  assign con_push = d_state_q == RESP && d_console && d_write_q == WRITE && d_mask_q[3];
  // a full FIFO holds the port in RESP unless the head is leaving on this same edge
  assign con_stall = con_push && con_full && !con_pop;
  console_fifo #(.DEPTH(CONSOLE_DEPTH)) u_console_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(con_push && !con_stall),
    .data_i(d_wdata_q[7:0]),
    .valid_o(console_valid),
    .data_o(console_data),
    .ready_i(console_ready),
    .full_o(con_full),
    .empty_o(con_empty)
  );
`else
  assign d_console = 1'b0;
  assign con_full = 1'b0;
  assign con_empty = 1'b1;
  assign con_stall = 1'b0;
  assign console_valid = 1'b0;
  assign console_data = 8'h0;
`endif
  assign d_commit = d_state_q == RESP && d_write_q == WRITE && d_in_range && !d_console;
  assign instruction_memory_interface_data = i_data_q;
  assign instruction_memory_interface_ready = i_ready_q;
  assign data_memory_interface_read_data = d_rdata_q;
  assign data_memory_interface_ready = d_ready_q;
  assign data_memory_interface_error = d_error_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i_state_q <= IDLE;
      i_cnt_q <= '0;
      i_word_q <= '0;
      i_data_q <= '0;
      i_ready_q <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      i_data_q <= '0;
      case (i_state_q)
        IDLE: if (instruction_memory_interface_enable) begin
          i_word_q <= instruction_memory_interface_address[31:2];
          i_cnt_q <= WAIT_LOAD;
          i_state_q <= ACCEPT_NEXT;
        end
        WAIT: begin
          i_cnt_q <= i_cnt_q - 4'd1;
          i_state_q <= !instruction_memory_interface_enable ? IDLE : (i_cnt_q == '0 ? RESP : WAIT);
        end
        RESP: begin
          i_ready_q <= 1'b1;
          i_data_q <= i_in_range ? mem[i_word_q[AW-1:0]] : '0;
          i_state_q <= IDLE;
        end
        default: i_state_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      d_state_q <= IDLE;
      d_cnt_q <= '0;
      d_word_q <= '0;
      d_write_q <= READ;
      d_mask_q <= '0;
      d_wdata_q <= '0;
      d_rdata_q <= '0;
      d_ready_q <= 1'b0;
      d_error_q <= 1'b0;
    end else begin
      d_ready_q <= 1'b0;
      d_error_q <= 1'b0;
      d_rdata_q <= '0;
      case (d_state_q)
        IDLE: if (data_memory_interface_enable) begin
          d_word_q <= data_memory_interface_address[31:2];
          d_write_q <= data_memory_interface_state;
          d_mask_q <= data_memory_interface_frame_mask;
          d_wdata_q <= data_memory_interface_write_data;
          d_cnt_q <= WAIT_LOAD;
          d_state_q <= ACCEPT_NEXT;
        end
        WAIT: begin
          d_cnt_q <= d_cnt_q - 4'd1;
          d_state_q <= !data_memory_interface_enable ? IDLE : (d_cnt_q == '0 ? RESP : WAIT);
        end
        RESP: if (!con_stall) begin
          d_ready_q <= 1'b1;
          d_error_q <= !d_console && !d_in_range;
          d_rdata_q <= d_write_q == WRITE ? '0 :
                       d_console ? {30'b0, con_full, con_empty} :
                       d_in_range ? mem[d_word_q[AW-1:0]] : '0;
          d_state_q <= IDLE;
        end
        default: d_state_q <= IDLE;
      endcase
    end
  // backing store is never reset; nonblocking commit keeps a same-edge instruction read on the old word
  always_ff @(posedge clk)
    if (d_commit) mem[d_word_q[AW-1:0]] <= merge_bytes(mem[d_word_q[AW-1:0]], d_wdata_q, d_mask_q);
endmodule

// File: tb/tb_memory_subsystem.sv
// tb_memory_subsystem: vector table, hand-written corner sequences and randomized traffic against a word-array model.
module tb_memory_subsystem;
  localparam int DEPTH = 256;
  localparam int LAT = 3;
  localparam logic [31:0] CON = 32'h1000_0000;
  localparam int NV = 18;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic i_en = 1'b0, i_ready;
  logic [31:0] i_addr = '0, i_data;
  logic d_en = 1'b0, d_st = 1'b0, d_ready, d_err;
  logic [31:0] d_addr = '0, d_wd = '0, d_rdata;
  logic [3:0] d_mask = '0;
  logic console_valid, console_ready = 1'b0;
  logic [7:0] console_data;
  int vectors = 0, miscompares = 0;
  vec_t tbl [NV];
  logic [31:0] model [DEPTH];
  logic [31:0] rd, idata, a, v, expv;
  logic err, seen;
  logic [3:0] m;
  int lat, ilat, w, op, got;

  memory_subsystem #(
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .CONSOLE_ADDRESS(CON), .CONSOLE_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instruction_memory_interface_enable(i_en),
    .instruction_memory_interface_address(i_addr),
    .instruction_memory_interface_data(i_data),
    .instruction_memory_interface_ready(i_ready),
    .data_memory_interface_enable(d_en),
    .data_memory_interface_state(d_st),
    .data_memory_interface_address(d_addr),
    .data_memory_interface_frame_mask(d_mask),
    .data_memory_interface_write_data(d_wd),
    .data_memory_interface_read_data(d_rdata),
    .data_memory_interface_ready(d_ready),
    .data_memory_interface_error(d_err),
    .console_valid(console_valid),
    .console_data(console_data),
    .console_ready(console_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] mk);
    return {{8{mk[0]}}, {8{mk[1]}}, {8{mk[2]}}, {8{mk[3]}}};
  endfunction

  // lat = posedges from the accepting edge to the edge that raised ready
  task automatic d_access(input logic wr, input logic [31:0] addr, input logic [3:0] mk, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic e, output int l);
    d_en = 1'b1; d_st = wr; d_addr = addr; d_mask = mk; d_wd = wdat;
    @(negedge clk);
    l = 0;
    while (!d_ready && l < 60) begin
      @(negedge clk);
      l++;
    end
    rdat = d_rdata; e = d_err; d_en = 1'b0;
    @(negedge clk);
    chk("d_ready_one_cycle", 32'(d_ready), 32'(0));
    chk("d_rdata_idle_zero", d_rdata, 32'h0);
  endtask

  task automatic i_access(input logic [31:0] addr, output logic [31:0] dat, output int l);
    i_en = 1'b1; i_addr = addr;
    @(negedge clk);
    l = 0;
    while (!i_ready && l < 60) begin
      @(negedge clk);
      l++;
    end
    dat = i_data; i_en = 1'b0;
    @(negedge clk);
    chk("i_ready_one_cycle", 32'(i_ready), 32'(0));
    chk("i_data_idle_zero", i_data, 32'h0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h20,  4'hF, 32'h1122_3344, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'h20,  4'h8, 32'hAABB_CCDD, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h20,  4'h0, 32'h0, 32'h1122_33DD, 1'b0};
    tbl[3]  = '{1'b0, 32'h23,  4'h0, 32'h0, 32'h1122_33DD, 1'b0};
    tbl[4]  = '{1'b1, 32'h24,  4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 32'h24,  4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 32'h25,  4'h0, 32'h0, 32'hCAFE_F00D, 1'b0};
    tbl[7]  = '{1'b1, 32'h28,  4'hF, 32'h0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 32'h28,  4'h5, 32'h1234_5678, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h28,  4'h0, 32'h0, 32'h1200_5600, 1'b0};
    tbl[10] = '{1'b1, 32'h3FC, 4'hF, 32'h0BAD_BEEF, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h3FC, 4'h0, 32'h0, 32'h0BAD_BEEF, 1'b0};
    tbl[12] = '{1'b1, 32'h0,   4'hF, 32'h0F0F_0F0F, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 32'h400, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 32'h400, 4'hF, 32'h1234_5678, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 32'h0,   4'h0, 32'h0, 32'h0F0F_0F0F, 1'b0};
`ifdef MEMORY_SUBSYSTEM_CONSOLE_EN
    tbl[16] = '{1'b0, CON, 4'h0, 32'h0, 32'h1, 1'b0};
`else
    tbl[16] = '{1'b0, CON, 4'h0, 32'h0, 32'h0, 1'b1};
`endif
    tbl[17] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_i_ready", 32'(i_ready), 32'(0));
    chk("rst_i_data", i_data, 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'(0));
    chk("rst_d_error", 32'(d_err), 32'(0));
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_console_valid", 32'(console_valid), 32'(0));
    chk("rst_console_data", 32'(console_data), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      d_access(tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].wd, rd, err, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_error", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
    end

    d_access(1'b1, 32'h10, 4'hF, 32'h4444_0004, rd, err, lat);
    i_access(32'h10, idata, ilat);
    chk("lat3_ifetch_cycle", 32'(ilat), 32'(4));
    chk("lat3_ifetch_data", idata, 32'h4444_0004);

    d_access(1'b1, 32'h20, 4'hF, 32'h9, rd, err, lat);
    fork
      i_access(32'h20, idata, ilat);
      d_access(1'b1, 32'h20, 4'hF, 32'h5, rd, err, lat);
    join
    chk("rbw_old_data", idata, 32'h9);
    chk("rbw_same_edge", 32'(ilat), 32'(lat));
    i_access(32'h20, idata, ilat);
    chk("rbw_new_data", idata, 32'h5);

    d_en = 1'b1; d_st = 1'b1; d_addr = 32'h24; d_mask = 4'hF; d_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    d_en = 1'b0; seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= d_ready;
    end
    chk("abort_no_ready", 32'(seen), 32'(0));
    d_access(1'b0, 32'h24, 4'h0, 32'h0, rd, err, lat);
    chk("abort_no_write", rd, 32'hCAFE_F00D);

    d_en = 1'b1; d_st = 1'b1; d_addr = 32'h20; d_mask = 4'hF; d_wd = 32'h77;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; d_en = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", 32'(d_ready), 32'(0));
    chk("rst_wait_rdata", d_rdata, 32'h0);
    reset = 1'b0; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= d_ready;
    end
    chk("rst_wait_discarded", 32'(seen), 32'(0));
    d_access(1'b0, 32'h20, 4'h0, 32'h0, rd, err, lat);
    chk("rst_keeps_memory", rd, 32'h5);

`ifdef MEMORY_SUBSYSTEM_CONSOLE_EN
    console_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d_access(1'b1, CON, 4'b1000, 32'hA5A5_A500 | 32'(32'h41 + k), rd, err, lat);
      chk("con_push_latency", 32'(lat), 32'(LAT + 1));
    end
    d_access(1'b0, CON, 4'h0, 32'h0, rd, err, lat);
    chk("con_status_full", rd, 32'h2);
    got = 0;
    fork
      d_access(1'b1, CON, 4'b1000, 32'h1234_5649, rd, err, lat);
      begin
        repeat (10) @(negedge clk);
        chk("con_stall_no_ready", 32'(d_ready), 32'(0));
        chk("con_full_valid", 32'(console_valid), 32'(1));
        chk("con_head_byte", 32'(console_data), 32'h41);
        got = 1; console_ready = 1'b1;
        @(negedge clk);
        chk("con_ready_after_pop", 32'(d_ready), 32'(1));
        repeat (12) begin
          if (console_valid) begin
            chk("con_byte_order", 32'(console_data), 32'(32'h41 + got));
            got++;
          end
          @(negedge clk);
        end
      end
    join
    chk("con_stalled_latency", 32'(lat > LAT + 1 && lat < 60), 32'(1));
    chk("con_byte_count", 32'(got), 32'(9));
    d_access(1'b0, CON, 4'h0, 32'h0, rd, err, lat);
    chk("con_status_empty", rd, 32'h1);
`else
    d_access(1'b1, CON, 4'b1000, 32'h41, rd, err, lat);
    chk("con_off_error", 32'(err), 32'(1));
    chk("con_off_valid", 32'(console_valid), 32'(0));
    chk("con_off_data", 32'(console_data), 32'h0);
`endif

    for (int k = 64; k < 96; k++) begin
      v = $urandom;
      d_access(1'b1, 32'(k * 4), 4'hF, v, rd, err, lat);
      model[k] = v;
    end
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      w = 64 + int'($urandom_range(0, 31));
      a = 32'(w * 4) + 32'($urandom_range(0, 3));
      v = $urandom;
      m = 4'($urandom_range(0, 15));
      if (op <= 2) begin
        d_access(1'b1, a, m, v, rd, err, lat);
        model[w] = (model[w] & ~lanes(m)) | (v & lanes(m));
        chk("rnd_write_err", 32'(err), 32'(0));
        chk("rnd_write_lat", 32'(lat), 32'(LAT + 1));
      end else if (op <= 4) begin
        d_access(1'b0, a, m, v, rd, err, lat);
        chk("rnd_read_data", rd, model[w]);
        chk("rnd_read_err", 32'(err), 32'(0));
      end else if (op <= 6) begin
        i_access(a, idata, ilat);
        chk("rnd_ifetch_data", idata, model[w]);
        chk("rnd_ifetch_lat", 32'(ilat), 32'(LAT + 1));
      end else if (op == 7) begin
        a = 32'((DEPTH + int'($urandom_range(0, 4095))) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          d_access($urandom_range(0, 1) == 1, a, m, v, rd, err, lat);
          chk("rnd_oor_data", rd, 32'h0);
          chk("rnd_oor_err", 32'(err), 32'(1));
        end else begin
          i_access(a, idata, ilat);
          chk("rnd_oor_ifetch", idata, 32'h0);
        end
      end else begin
        expv = model[w];
        fork
          i_access(a, idata, ilat);
          d_access(1'b1, a, m, v, rd, err, lat);
        join
        model[w] = (model[w] & ~lanes(m)) | (v & lanes(m));
        chk("rnd_rbw_old", idata, expv);
        chk("rnd_rbw_lat", 32'(ilat), 32'(lat));
      end
    end
    for (int k = 64; k < 96; k++) begin
      d_access(1'b0, 32'(k * 4), 4'h0, 32'h0, rd, err, lat);
      chk("final_sweep", rd, model[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
